instr_fault_injector: RTL and testbench

Synthesizable fault-injection stage between instruction memory and core 0's instruction read-data input in `cevero_soc`. It replaces testbench `force`-based corruption with a deterministic, LFSR-driven engine. The engine:
- flips bits in fetched instruction words inside a programmable address window;
- watches the fault-tolerance module's error flag;
- keeps injection, detection, undetected and spurious statistics, plus the latency of the last detection.

---
 rtl/instr_fault_injector.sv | 168 ++++++++++++++++
 tb/tb_instr_fault_injector.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fault_injector.sv
// LFSR-driven instruction-word fault injector with detection statistics for core 0's fetch path.
// Optional double-bit flip mask when FI_MULTI_BIT_EN is defined; single-bit mask otherwise.
module instr_fault_injector #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] ADDR_LIMIT  = 32'h100,
  parameter int          PROB_THRESH = 3,
  parameter int          MAX_FAULTS  = 10,
  parameter int          TIMEOUT     = 1000,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic [31:0]       instr_addr_i,
  input  logic              instr_rvalid_i,
  input  logic [DATA_W-1:0] instr_rdata_i,
  output logic [DATA_W-1:0] instr_rdata_o,
  input  logic              error_i,
  output logic              fault_active_o,
  output logic              busy_o,
  output logic [7:0]        inj_count_o,
  output logic [7:0]        det_count_o,
  output logic [7:0]        undet_count_o,
  output logic [7:0]        spur_count_o,
  output logic [15:0]       last_latency_o
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] PROB_U    = PROB_THRESH;
  localparam logic [31:0] MAX_U     = MAX_FAULTS;
  localparam logic [15:0] TIMEOUT_U = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_DET,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_lfsr;
  logic              r_err_q;
  logic [7:0]        r_inj_cnt;
  logic [7:0]        r_det_cnt;
  logic [7:0]        r_undet_cnt;
  logic [7:0]        r_spur_cnt;
  logic [15:0]       r_lat_cnt;
  logic [15:0]       r_last_lat;

  logic              w_rise;
  logic              w_addr_ok;
  logic              w_prob_ok;
  logic              w_budget_ok;
  logic              w_budget_hit;
  logic              w_timeout;
  logic              w_inject;
  logic              w_detect;
  logic              w_undetect;
  logic [DATA_W-1:0] w_mask;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_rise       = error_i & ~r_err_q;
  assign w_addr_ok    = instr_addr_i < ADDR_LIMIT;
  assign w_prob_ok    = {27'd0, r_lfsr[4:0]} < PROB_U;
  assign w_budget_ok  = {24'd0, r_inj_cnt} < MAX_U;
  assign w_budget_hit = {24'd0, r_inj_cnt} == MAX_U;
  assign w_timeout    = r_lat_cnt == TIMEOUT_U;

`ifdef FI_MULTI_BIT_EN
  assign w_mask = (DATA_W'(1) << r_lfsr[9:5]) | (DATA_W'(1) << r_lfsr[14:10]);
`else
  assign w_mask = DATA_W'(1) << r_lfsr[9:5];
`endif

  // Next-state and per-cycle event decode
  always_comb begin
    w_state_nxt = r_state;
    w_inject    = 1'b0;
    w_detect    = 1'b0;
    w_undetect  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm_i) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!arm_i) begin
          w_state_nxt = S_IDLE;
        end else if (instr_rvalid_i && w_addr_ok && w_prob_ok && w_budget_ok) begin
          w_inject    = 1'b1;
          w_state_nxt = S_WAIT_DET;
        end
      end
      S_WAIT_DET: begin
        // A rise on the timeout edge still counts as a detection.
        if (w_rise)         w_detect   = 1'b1;
        else if (w_timeout) w_undetect = 1'b1;
        if (w_detect || w_undetect) begin
          if (w_budget_hit) w_state_nxt = S_DONE;
          else if (arm_i)   w_state_nxt = S_ARMED;
          else              w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, LFSR and statistics registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_err_q     <= 1'b0;
      r_inj_cnt   <= 8'd0;
      r_det_cnt   <= 8'd0;
      r_undet_cnt <= 8'd0;
      r_spur_cnt  <= 8'd0;
      r_lat_cnt   <= 16'd0;
      r_last_lat  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= lfsr_step(r_lfsr);
      r_err_q <= error_i;

      if (w_inject) begin
        r_inj_cnt <= sat_inc8(r_inj_cnt);
        r_lat_cnt <= 16'd1;
      end else if (r_state == S_WAIT_DET) begin
        if (w_detect) begin
          r_det_cnt  <= sat_inc8(r_det_cnt);
          r_last_lat <= r_lat_cnt;
        end else if (w_undetect) begin
          r_undet_cnt <= sat_inc8(r_undet_cnt);
        end else begin
          r_lat_cnt <= sat_inc16(r_lat_cnt);
        end
      end

      if (w_rise && (r_state != S_WAIT_DET)) r_spur_cnt <= sat_inc8(r_spur_cnt);
    end
  end

  assign instr_rdata_o  = w_inject ? (instr_rdata_i ^ w_mask) : instr_rdata_i;
  assign fault_active_o = w_inject;
  assign busy_o         = r_state == S_WAIT_DET;
  assign inj_count_o    = r_inj_cnt;
  assign det_count_o    = r_det_cnt;
  assign undet_count_o  = r_undet_cnt;
  assign spur_count_o   = r_spur_cnt;
  assign last_latency_o = r_last_lat;

endmodule

// File: tb/tb_instr_fault_injector.sv
// Scoreboard bench for instr_fault_injector: always-fire probability, short timeout, budget of 10.
module tb_instr_fault_injector;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst, arm, rvalid, err;
  logic [31:0] addr, rdata_i;
  logic [31:0] rdata_o;
  logic        fault_act, busy;
  logic [7:0]  inj_c, det_c, undet_c, spur_c;
  logic [15:0] last_lat;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  instr_fault_injector #(
    .DATA_W(32), .ADDR_LIMIT(32'h100), .PROB_THRESH(32),
    .MAX_FAULTS(10), .TIMEOUT(20), .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm),
    .instr_addr_i(addr), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata_i),
    .instr_rdata_o(rdata_o), .error_i(err), .fault_active_o(fault_act),
    .busy_o(busy), .inj_count_o(inj_c), .det_count_o(det_c),
    .undet_count_o(undet_c), .spur_count_o(spur_c), .last_latency_o(last_lat)
  );

  always @(posedge clk) m_lfsr <= rst ? SEED : (m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1));

  function automatic logic [31:0] exp_mask(input logic [31:0] l);
`ifdef FI_MULTI_BIT_EN
    return (32'd1 << l[9:5]) | (32'd1 << l[14:10]);
`else
    return 32'd1 << l[9:5];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] a, input logic [31:0] d, input logic inj);
    exp_t e;
    rvalid  = rv;
    addr    = a;
    rdata_i = d;
    e.data  = inj ? (d ^ exp_mask(m_lfsr)) : d;
    e.fault = inj;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; arm = 1'b0; err = 1'b0;
    drive(1'b1, 32'h40, 32'h0000_0013, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (rdata_o !== e.data || fault_act !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_outputs data=%h fault=%b busy=%b want data=%h fault=0 busy=0", rdata_o, fault_act, busy, e.data);
    end
    total++;
    if ({inj_c, det_c, undet_c, spur_c, last_lat} !== 48'd0) begin
      bad++; $display("FAIL reset_counters got=%h want=0", {inj_c, det_c, undet_c, spur_c, last_lat});
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i[0], 32'h40, (i[1] ? 32'h0 : 32'h0000_0013), 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== e.fault) begin
        bad++; $display("FAIL disarmed_pass[%0d] data=%h fault=%b want data=%h fault=%b", i, rdata_o, fault_act, e.data, e.fault);
      end
      step();
    end
    total++;
    if (inj_c !== 8'd0 || spur_c !== 8'd0) begin
      bad++; $display("FAIL disarmed_counts inj=%0d spur=%0d want 0 0", inj_c, spur_c);
    end
  endtask

  task automatic test_single_inject();
    exp_t e;
    arm = 1'b1;
    drive(1'b0, 32'h40, 32'h0000_0013, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++;
    if (rdata_o !== e.data || fault_act !== e.fault) begin
      bad++; $display("FAIL arm_cycle data=%h fault=%b want data=%h fault=%b", rdata_o, fault_act, e.data, e.fault);
    end
    step();
    drive(1'b1, 32'h40, 32'h0000_0013, 1'b1);
    @(negedge clk); e = exp_q.pop_front();
    total++;
    if (rdata_o !== e.data || fault_act !== 1'b1 || $countones(rdata_o ^ rdata_i) != 1) begin
      bad++; $display("FAIL inject_word data=%h fault=%b want data=%h fault=1", rdata_o, fault_act, e.data);
    end
    step();
    for (int k = 1; k <= 5; k++) begin
      err = (k == 5);
      drive(1'b1, 32'h40, 32'h0000_0013, 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== 1'b0 || busy !== 1'b1 || inj_c !== 8'd1) begin
        bad++; $display("FAIL wait_det[%0d] data=%h fault=%b busy=%b inj=%0d want data=%h fault=0 busy=1 inj=1", k, rdata_o, fault_act, busy, inj_c, e.data);
      end
      step();
    end
    err = 1'b0;
    drive(1'b0, 32'h40, 32'h0000_0013, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++;
    if (det_c !== 8'd1 || last_lat !== 16'd5 || busy !== 1'b0 || rdata_o !== e.data) begin
      bad++; $display("FAIL detect_lat5 det=%0d lat=%0d busy=%b want det=1 lat=5 busy=0", det_c, last_lat, busy);
    end
    step();
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      err = 1'b0;
      drive(1'b1, 32'h80, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== 1'b1) begin
        bad++; $display("FAIL to_inject[%0d] data=%h fault=%b want data=%h fault=1", pass, rdata_o, fault_act, e.data);
      end
      step();
      for (int k = 1; k <= 20; k++) begin
        err = (pass == 1) && (k == 20);
        drive(1'b0, 32'h80, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk); e = exp_q.pop_front();
        total++;
        if (busy !== 1'b1 || rdata_o !== e.data) begin
          bad++; $display("FAIL to_busy[%0d.%0d] busy=%b data=%h want busy=1 data=%h", pass, k, busy, rdata_o, e.data);
        end
        step();
      end
      err = 1'b0;
      drive(1'b0, 32'h80, 32'h0, 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (busy !== 1'b0 || undet_c !== 8'd1 || det_c !== 8'(1 + pass) || (pass == 1 && last_lat !== 16'd20)) begin
        bad++; $display("FAIL to_result[%0d] busy=%b undet=%0d det=%0d lat=%0d want busy=0 undet=1 det=%0d", pass, busy, undet_c, det_c, last_lat, 1 + pass);
      end
      step();
    end
  endtask

  task automatic test_spur_on_inject_edge();
    exp_t e;
    err = 1'b1;
    drive(1'b1, 32'h20, 32'h0000_0013, 1'b1);
    @(negedge clk); e = exp_q.pop_front();
    total++;
    if (rdata_o !== e.data || fault_act !== 1'b1) begin
      bad++; $display("FAIL spur_inject data=%h fault=%b want data=%h fault=1", rdata_o, fault_act, e.data);
    end
    step();
    for (int k = 1; k <= 3; k++) begin
      err = (k == 3);
      drive(1'b0, 32'h20, 32'h0000_0013, 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (spur_c !== 8'd1 || busy !== 1'b1 || rdata_o !== e.data) begin
        bad++; $display("FAIL spur_wait[%0d] spur=%0d busy=%b want spur=1 busy=1", k, spur_c, busy);
      end
      step();
    end
    err = 1'b0;
    drive(1'b0, 32'h20, 32'h0, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++;
    if (det_c !== 8'd3 || last_lat !== 16'd3 || spur_c !== 8'd1 || rdata_o !== e.data) begin
      bad++; $display("FAIL spur_detect det=%0d lat=%0d spur=%0d want det=3 lat=3 spur=1", det_c, last_lat, spur_c);
    end
    step();
  endtask

  task automatic test_addr_window();
    exp_t e;
    logic [31:0] addrs [4];
    logic        rvs   [4];
    addrs = '{32'h100, 32'hFFFF_FFF0, 32'h40, 32'h0};
    rvs   = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(rvs[i], addrs[i], 32'hA5A5_0F0F, 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL window[%0d] data=%h fault=%b busy=%b want data=%h fault=0 busy=0", i, rdata_o, fault_act, busy, e.data);
      end
      step();
    end
    total++;
    if (inj_c !== 8'd4) begin
      bad++; $display("FAIL window_inj inj=%0d want 4", inj_c);
    end
  endtask

  task automatic test_budget_done();
    exp_t e;
    for (int f = 0; f < 6; f++) begin
      err = 1'b0;
      drive(1'b1, 32'h0FC, 32'h1000_0000 + 32'(f), 1'b1);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== 1'b1) begin
        bad++; $display("FAIL budget_inject[%0d] data=%h fault=%b want data=%h fault=1", f, rdata_o, fault_act, e.data);
      end
      step();
      err = 1'b1;
      drive(1'b1, 32'h0FC, 32'h2000_0000 + 32'(f), 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL budget_wait[%0d] data=%h fault=%b busy=%b want data=%h fault=0 busy=1", f, rdata_o, fault_act, busy, e.data);
      end
      step();
    end
    err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0FC, 32'h0000_0013, 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL done_pass[%0d] data=%h fault=%b busy=%b want data=%h fault=0 busy=0", i, rdata_o, fault_act, busy, e.data);
      end
      step();
    end
    total++;
    if (inj_c !== 8'd10 || det_c !== 8'd9 || undet_c !== 8'd1 || last_lat !== 16'd1) begin
      bad++; $display("FAIL budget_counts inj=%0d det=%0d undet=%0d lat=%0d want 10 9 1 1", inj_c, det_c, undet_c, last_lat);
    end
    for (int i = 0; i < 2; i++) begin
      err = (i == 0);
      drive(1'b1, 32'h0FC, 32'h0000_0013, 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      total++;
      if (rdata_o !== e.data || fault_act !== 1'b0) begin
        bad++; $display("FAIL done_err[%0d] data=%h fault=%b want data=%h fault=0", i, rdata_o, fault_act, e.data);
      end
      step();
    end
    total++;
    if (spur_c !== 8'd2 || det_c !== 8'd9 || busy !== 1'b0) begin
      bad++; $display("FAIL done_spur spur=%0d det=%0d busy=%b want spur=2 det=9 busy=0", spur_c, det_c, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    rst = 1'b1;
    drive(1'b0, 32'h40, 32'h55, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    step();
    rst = 1'b0;
    drive(1'b0, 32'h40, 32'h55, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    step();
    drive(1'b1, 32'h40, 32'h0000_0055, 1'b1);
    @(negedge clk); e = exp_q.pop_front();
    total++;
    if (rdata_o !== e.data || fault_act !== 1'b1) begin
      bad++; $display("FAIL rst_inject data=%h fault=%b want data=%h fault=1", rdata_o, fault_act, e.data);
    end
    step();
    drive(1'b0, 32'h40, 32'h55, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    total++;
    if (busy !== 1'b1 || inj_c !== 8'd1) begin
      bad++; $display("FAIL rst_prewait busy=%b inj=%0d want busy=1 inj=1", busy, inj_c);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'h40, 32'h55, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    total++;
    if (busy !== 1'b0 || {inj_c, det_c, undet_c, spur_c, last_lat} !== 48'd0) begin
      bad++; $display("FAIL rst_mid_wait busy=%b counters=%h want busy=0 counters=0", busy, {inj_c, det_c, undet_c, spur_c, last_lat});
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; rvalid = 1'b0; err = 1'b0;
    addr = 32'h0; rdata_i = 32'h0;
    test_reset();
    test_single_inject();
    test_timeout();
    test_spur_on_inject_edge();
    test_addr_window();
    test_budget_done();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
